// File: rtl/axi_burst_beat_gen.sv
// axi_burst_beat_gen: expands one AXI4 AX descriptor into per-beat records
// (address, byte-lane window, strobe, index, last) for FIXED/INCR/WRAP bursts,
// and flags descriptors that break the AXI burst rules.
module axi_burst_beat_gen #(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  localparam int unsigned StrbWidth = DataWidth / 8,
  localparam int unsigned OffW      = $clog2(StrbWidth)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ax_valid_i,
  output logic                 ax_ready_o,
  input  logic [AddrWidth-1:0] ax_addr_i,
  input  logic [7:0]           ax_len_i,
  input  logic [2:0]           ax_size_i,
  input  logic [1:0]           ax_burst_i,
  output logic                 beat_valid_o,
  input  logic                 beat_ready_i,
  output logic [AddrWidth-1:0] beat_addr_o,
  output logic [7:0]           beat_idx_o,
  output logic [OffW-1:0]      beat_lower_o,
  output logic [OffW-1:0]      beat_upper_o,
  output logic [StrbWidth-1:0] beat_strb_o,
  output logic                 beat_last_o,
  output logic                 beat_err_o
);

  typedef enum logic {IDLE, BURST} state_t;

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;
  localparam logic [1:0] BurstRsvd  = 2'b11;
  localparam logic [2:0] MaxSize    = 3'(OffW);

  state_t               state_q;
  logic                 beat_valid_q;
  logic [AddrWidth-1:0] addr_q;
  logic [7:0]           idx_q;
  logic [OffW-1:0]      lower_q;
  logic [OffW-1:0]      upper_q;
  logic [StrbWidth-1:0] strb_q;
  logic                 last_q;
  logic                 err_q;

  // Latched descriptor context
  logic [7:0]           len_q;
  logic [1:0]           burst_q;
  logic [2:0]           size_q;
  logic [AddrWidth-1:0] wrap_base_q;
  logic [AddrWidth-1:0] wrap_total_q;

  logic accept;
  logic take_beat;
  logic update;

  // Descriptor decode
  logic [2:0]           in_size_eff;
  logic [AddrWidth-1:0] in_total;
  logic [AddrWidth-1:0] in_wrap_base;
  logic [AddrWidth-1:0] act_aligned;
  logic [AddrWidth-1:0] act_total;
  logic [AddrWidth-1:0] act_end;
  logic                 wrap_len_ok;
  logic                 page_cross;
  logic                 in_err;

  // Beat advance
  logic [AddrWidth-1:0] cur_nbytes;
  logic [AddrWidth-1:0] cur_inc;
  logic [AddrWidth-1:0] adv_addr;

  // Next beat record
  logic [AddrWidth-1:0] nxt_addr;
  logic [2:0]           nxt_size;
  logic                 nxt_err;
  logic [7:0]           nxt_idx;
  logic                 nxt_last;
  logic [OffW-1:0]      nxt_lower;
  logic [OffW-1:0]      nxt_upper;
  logic [OffW-1:0]      nxt_nm1;
  logic [StrbWidth-1:0] nxt_strb;

  assign ax_ready_o = (state_q == IDLE) || (beat_valid_q && beat_ready_i && last_q);
  assign accept     = ax_valid_i && ax_ready_o;
  assign take_beat  = beat_valid_q && beat_ready_i;
  assign update     = accept || (take_beat && !last_q);

  assign beat_valid_o = beat_valid_q;
  assign beat_addr_o  = addr_q;
  assign beat_idx_o   = idx_q;
  assign beat_lower_o = lower_q;
  assign beat_upper_o = upper_q;
  assign beat_strb_o  = strb_q;
  assign beat_last_o  = last_q;
  assign beat_err_o   = err_q;

  // Decode the incoming descriptor: clamped geometry and legality checks
  always_comb begin
    in_size_eff  = (ax_size_i > MaxSize) ? MaxSize : ax_size_i;
    in_total     = (AddrWidth'(ax_len_i) + AddrWidth'(1)) << in_size_eff;
    in_wrap_base = ax_addr_i & ~(in_total - AddrWidth'(1));

    act_aligned  = (ax_addr_i >> ax_size_i) << ax_size_i;
    act_total    = (AddrWidth'(ax_len_i) + AddrWidth'(1)) << ax_size_i;
    act_end      = act_aligned + act_total - AddrWidth'(1);
    page_cross   = (act_end >> 12) != (ax_addr_i >> 12);

    wrap_len_ok  = (ax_len_i == 8'd1) || (ax_len_i == 8'd3) ||
                   (ax_len_i == 8'd7) || (ax_len_i == 8'd15);

    in_err = (ax_size_i > MaxSize) ||
             (ax_burst_i == BurstRsvd) ||
             ((ax_burst_i == BurstWrap) && (!wrap_len_ok || (ax_addr_i != act_aligned))) ||
             ((ax_burst_i == BurstIncr) && page_cross);
  end

  // Incremental next-beat address from the current beat
  always_comb begin
    cur_nbytes = AddrWidth'(1) << size_q;
    cur_inc    = (addr_q & ~(cur_nbytes - AddrWidth'(1))) + cur_nbytes;
    // Wrap test is done as an offset from wrap_base so a window ending at
    // the top of the address space still wraps correctly.
    unique case (burst_q)
      BurstFixed: adv_addr = addr_q;
      BurstWrap:  adv_addr = ((cur_inc - wrap_base_q) >= wrap_total_q) ?
                             (cur_inc - wrap_total_q) : cur_inc;
      default:    adv_addr = cur_inc;
    endcase
  end

  // Select the next beat (fresh descriptor or advance) and derive its lanes
  always_comb begin
    if (accept) begin
      nxt_addr = ax_addr_i;
      nxt_size = in_size_eff;
      nxt_err  = in_err;
      nxt_idx  = 8'd0;
      nxt_last = (ax_len_i == 8'd0);
    end else begin
      nxt_addr = adv_addr;
      nxt_size = size_q;
      nxt_err  = err_q;
      nxt_idx  = idx_q + 8'd1;
      nxt_last = ((idx_q + 8'd1) == len_q);
    end
    nxt_nm1   = OffW'((AddrWidth'(1) << nxt_size) - AddrWidth'(1));
    nxt_lower = nxt_addr[OffW-1:0];
    nxt_upper = (nxt_lower & ~nxt_nm1) + nxt_nm1;
    nxt_strb  = '0;
    for (int unsigned i = 0; i < StrbWidth; i++) begin
      nxt_strb[i] = !nxt_err && (OffW'(i) >= nxt_lower) && (OffW'(i) <= nxt_upper);
    end
  end

  // Burst FSM with registered beat record
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      beat_valid_q <= 1'b0;
      addr_q       <= '0;
      idx_q        <= '0;
      lower_q      <= '0;
      upper_q      <= '0;
      strb_q       <= '0;
      last_q       <= 1'b0;
      err_q        <= 1'b0;
      len_q        <= '0;
      burst_q      <= '0;
      size_q       <= '0;
      wrap_base_q  <= '0;
      wrap_total_q <= '0;
    end else begin
      unique case (state_q)
        IDLE:  if (accept) state_q <= BURST;
        BURST: if (take_beat && last_q && !accept) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      if (accept) begin
        len_q        <= ax_len_i;
        burst_q      <= ax_burst_i;
        size_q       <= in_size_eff;
        wrap_base_q  <= in_wrap_base;
        wrap_total_q <= in_total;
      end

      if (update) begin
        beat_valid_q <= 1'b1;
        addr_q       <= nxt_addr;
        idx_q        <= nxt_idx;
        lower_q      <= nxt_lower;
        upper_q      <= nxt_upper;
        strb_q       <= nxt_strb;
        last_q       <= nxt_last;
        err_q        <= nxt_err;
      end else if (take_beat) begin
        beat_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_burst_beat_gen.sv
// Testbench for axi_burst_beat_gen: directed vector table, hand-written
// backpressure / back-to-back / reset sequences, and randomized descriptors
// checked against an arithmetic reference model.
module tb_axi_burst_beat_gen;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int SW = DW / 8;
  localparam int OW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          ax_valid;
  logic          ax_ready;
  logic [AW-1:0] ax_addr;
  logic [7:0]    ax_len;
  logic [2:0]    ax_size;
  logic [1:0]    ax_burst;
  logic          beat_valid;
  logic          beat_ready;
  logic [AW-1:0] beat_addr;
  logic [7:0]    beat_idx;
  logic [OW-1:0] beat_lower;
  logic [OW-1:0] beat_upper;
  logic [SW-1:0] beat_strb;
  logic          beat_last;
  logic          beat_err;

  always #5 clk = ~clk;

  axi_burst_beat_gen #(.AddrWidth(AW), .DataWidth(DW)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .ax_valid_i   (ax_valid),
    .ax_ready_o   (ax_ready),
    .ax_addr_i    (ax_addr),
    .ax_len_i     (ax_len),
    .ax_size_i    (ax_size),
    .ax_burst_i   (ax_burst),
    .beat_valid_o (beat_valid),
    .beat_ready_i (beat_ready),
    .beat_addr_o  (beat_addr),
    .beat_idx_o   (beat_idx),
    .beat_lower_o (beat_lower),
    .beat_upper_o (beat_upper),
    .beat_strb_o  (beat_strb),
    .beat_last_o  (beat_last),
    .beat_err_o   (beat_err)
  );

  typedef struct packed {
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } desc_t;

  typedef struct packed {
    logic [63:0] addr;
    logic [7:0]  idx;
    logic [2:0]  lower;
    logic [2:0]  upper;
    logic [7:0]  strb;
    logic        last;
    logic        err;
  } beat_t;

  typedef struct packed {
    desc_t            d;
    logic             err;
    logic [3:0][63:0] a;
    logic [3:0][2:0]  lo;
    logic [3:0][2:0]  up;
    logic [3:0][7:0]  st;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Reference: each beat computed directly from the burst rules
  task automatic model(input desc_t d, output beat_t q[$]);
    int unsigned    se, lo, up;
    longint unsigned n, al, tot, wb, an, ta, tt, a;
    bit             err;
    beat_t          b;
    q.delete();
    se  = (d.size > 3) ? 3 : d.size;
    n   = 64'd1 << se;
    al  = d.addr / n * n;
    tot = n * (d.len + 1);
    wb  = d.addr & ~(tot - 1);
    an  = 64'd1 << d.size;
    ta  = d.addr / an * an;
    tt  = an * (d.len + 1);
    err = (an > SW) || (d.burst == 2'b11) ||
          (d.burst == 2'b10 && !(d.len inside {8'd1, 8'd3, 8'd7, 8'd15})) ||
          (d.burst == 2'b10 && d.addr != ta) ||
          (d.burst == 2'b01 && ((ta + tt - 1) >> 12) != (d.addr >> 12));
    for (int i = 0; i <= int'(d.len); i++) begin
      if (i == 0 || d.burst == 2'b00) a = d.addr;
      else begin
        a = al + i * n;
        if (d.burst == 2'b10 && a >= wb + tot) a = a - tot;
      end
      lo = a % SW;
      up = (a / n * n) % SW + n - 1;
      b.addr  = a;
      b.idx   = 8'(i);
      b.lower = 3'(lo);
      b.upper = 3'(up);
      b.strb  = err ? 8'h00 : 8'(((1 << (up + 1)) - 1) & ~((1 << lo) - 1));
      b.last  = (i == int'(d.len));
      b.err   = err;
      q.push_back(b);
    end
  endtask

  task automatic from_vec(input vec_t v, output beat_t q[$]);
    beat_t b;
    q.delete();
    for (int i = 0; i <= int'(v.d.len); i++) begin
      b.addr  = v.a[i];
      b.idx   = 8'(i);
      b.lower = v.lo[i];
      b.upper = v.up[i];
      b.strb  = v.st[i];
      b.last  = (i == int'(v.d.len));
      b.err   = v.err;
      q.push_back(b);
    end
  endtask

  // Present a descriptor; returns at the negedge after acceptance
  task automatic start_desc(input desc_t d);
    bit ok = 0;
    @(negedge clk);
    ax_valid = 1'b1;
    ax_addr  = d.addr;
    ax_len   = d.len;
    ax_size  = d.size;
    ax_burst = d.burst;
    for (int g = 0; g < 50; g++) begin
      #1;
      if (ax_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: got ready 0 required 1");
    end
    @(negedge clk);
    ax_valid = 1'b0;
  endtask

  // Consume and check beats; optional stall, random ready, chained descriptor
  task automatic check_beats(input beat_t exp[$], input int stall_at, input int stall_n,
                             input bit rnd, input bit chain, input desc_t nd);
    int k = 0;
    int st = 0;
    int guard = 0;
    bit rdy;
    while (k < exp.size() && guard < 4000) begin
      chk("valid", beat_valid, 1);
      chk("addr", beat_addr, exp[k].addr);
      chk("idx", beat_idx, exp[k].idx);
      chk("lower", beat_lower, exp[k].lower);
      chk("upper", beat_upper, exp[k].upper);
      chk("strb", beat_strb, exp[k].strb);
      chk("last", beat_last, exp[k].last);
      chk("err", beat_err, exp[k].err);
      rdy = 1'b1;
      if (k == stall_at && st < stall_n) begin rdy = 1'b0; st++; end
      else if (rnd) rdy = ($urandom_range(0, 3) != 0);
      beat_ready = rdy;
      if (rdy && chain && k == exp.size() - 1) begin
        ax_valid = 1'b1;
        ax_addr  = nd.addr;
        ax_len   = nd.len;
        ax_size  = nd.size;
        ax_burst = nd.burst;
      end
      #1;
      if (rdy && chain && k == exp.size() - 1) chk("b2b_ready", ax_ready, 1);
      @(negedge clk);
      guard++;
      if (rdy) k++;
    end
    if (k < exp.size()) begin
      n_cmp++; n_bad++;
      $display("FAIL beat_timeout: got %0d beats required %0d", k, exp.size());
    end
    beat_ready = 1'b1;
    if (chain) ax_valid = 1'b0;
    else begin
      chk("idle_valid", beat_valid, 0);
      chk("idle_ready", ax_ready, 1);
    end
  endtask

  vec_t  tbl[7];
  beat_t e0[$];
  beat_t e1[$];
  desc_t d;
  desc_t nod;

  initial begin
    tbl[0] = '{d:'{addr:64'h1003, len:8'd3, size:3'd2, burst:2'b01}, err:1'b0,
               a:{64'h100C, 64'h1008, 64'h1004, 64'h1003},
               lo:{3'd4, 3'd0, 3'd4, 3'd3}, up:{3'd7, 3'd3, 3'd7, 3'd3},
               st:{8'hF0, 8'h0F, 8'hF0, 8'h08}};
    tbl[1] = '{d:'{addr:64'h38, len:8'd3, size:3'd3, burst:2'b10}, err:1'b0,
               a:{64'h30, 64'h28, 64'h20, 64'h38},
               lo:{3'd0, 3'd0, 3'd0, 3'd0}, up:{3'd7, 3'd7, 3'd7, 3'd7},
               st:{8'hFF, 8'hFF, 8'hFF, 8'hFF}};
    tbl[2] = '{d:'{addr:64'h104, len:8'd2, size:3'd1, burst:2'b00}, err:1'b0,
               a:{64'h0, 64'h104, 64'h104, 64'h104},
               lo:{3'd0, 3'd4, 3'd4, 3'd4}, up:{3'd0, 3'd5, 3'd5, 3'd5},
               st:{8'h00, 8'h30, 8'h30, 8'h30}};
    tbl[3] = '{d:'{addr:64'h38, len:8'd2, size:3'd3, burst:2'b10}, err:1'b1,
               a:{64'h0, 64'h30, 64'h28, 64'h38},
               lo:{3'd0, 3'd0, 3'd0, 3'd0}, up:{3'd0, 3'd7, 3'd7, 3'd7},
               st:'0};
    tbl[4] = '{d:'{addr:64'hFF8, len:8'd1, size:3'd3, burst:2'b01}, err:1'b1,
               a:{64'h0, 64'h0, 64'h1000, 64'hFF8},
               lo:{3'd0, 3'd0, 3'd0, 3'd0}, up:{3'd0, 3'd0, 3'd7, 3'd7},
               st:'0};
    tbl[5] = '{d:'{addr:64'h13, len:8'd0, size:3'd4, burst:2'b01}, err:1'b1,
               a:{64'h0, 64'h0, 64'h0, 64'h13},
               lo:{3'd0, 3'd0, 3'd0, 3'd3}, up:{3'd0, 3'd0, 3'd0, 3'd7},
               st:'0};
    tbl[6] = '{d:'{addr:64'h22, len:8'd0, size:3'd1, burst:2'b11}, err:1'b1,
               a:{64'h0, 64'h0, 64'h0, 64'h22},
               lo:{3'd0, 3'd0, 3'd0, 3'd2}, up:{3'd0, 3'd0, 3'd0, 3'd3},
               st:'0};
    nod = '0;

    rst = 1'b1; ax_valid = 1'b0; ax_addr = '0; ax_len = '0; ax_size = '0; ax_burst = '0;
    beat_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", beat_valid, 0);
    chk("rst_ready", ax_ready, 1);
    chk("rst_addr", beat_addr, 0);
    chk("rst_idx", beat_idx, 0);
    chk("rst_strb", beat_strb, 0);
    chk("rst_lanes", {beat_lower, beat_upper}, 0);
    chk("rst_last_err", {beat_last, beat_err}, 0);
    rst = 1'b0;

    // Directed vectors
    for (int i = 0; i < 7; i++) begin
      from_vec(tbl[i], e0);
      start_desc(tbl[i].d);
      check_beats(e0, -1, 0, 0, 0, nod);
    end

    // Backpressure: 3 stalled cycles at idx 1
    from_vec(tbl[0], e0);
    start_desc(tbl[0].d);
    check_beats(e0, 1, 3, 0, 0, nod);

    // Back-to-back: second descriptor accepted on the last beat, no gap
    from_vec(tbl[0], e0);
    from_vec(tbl[1], e1);
    start_desc(tbl[0].d);
    check_beats(e0, -1, 0, 0, 1, tbl[1].d);
    check_beats(e1, -1, 0, 0, 0, nod);

    // Reset mid-burst at idx 2
    d = '{addr:64'h200, len:8'd7, size:3'd3, burst:2'b01};
    start_desc(d);
    beat_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("pre_rst_idx", beat_idx, 2);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", beat_valid, 0);
    chk("mid_rst_ready", ax_ready, 1);
    chk("mid_rst_addr", beat_addr, 0);
    chk("mid_rst_idx", beat_idx, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("post_rst_valid", beat_valid, 0);
      chk("post_rst_ready", ax_ready, 1);
    end

    // Randomized descriptors with random backpressure
    for (int r = 0; r < 80; r++) begin
      d.addr  = {32'h0, $urandom()};
      d.len   = 8'($urandom_range(0, 15));
      d.size  = 3'($urandom_range(0, 4));
      d.burst = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      if (d.burst == 2'b10 && $urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 3))
          0: d.len = 8'd1;
          1: d.len = 8'd3;
          2: d.len = 8'd7;
          default: d.len = 8'd15;
        endcase
        d.addr = (d.addr >> d.size) << d.size;
      end
      model(d, e0);
      start_desc(d);
      check_beats(e0, -1, 0, 1, 0, nod);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_burst_beat_gen.md
# axi_burst_beat_gen

Sequential per-beat expander for AXI4 bursts. It accepts one AX descriptor (addr/len/size/burst) and emits one beat record per cycle: beat address, byte-lane window, write strobe, index and last flag. It implements the AXI beat-address and byte-lane rules for FIXED, INCR and WRAP bursts, and flags protocol-illegal descriptors. It sits in front of data-path blocks such as DMA back-ends, memory adapters and width converters that need per-beat addressing.

## Interface
- AddrWidth, 64: address width (≥ 12).
- DataWidth, 64: data bus width in bits; power of two, 8–1024. StrbWidth = DataWidth/8, OffW = $clog2(StrbWidth).
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- ax_valid_i  in  1  descriptor valid.
- ax_ready_o  out  1  descriptor accepted when valid && ready.
- ax_addr_i  in  AddrWidth  start address.
- ax_len_i  in  8  beats minus one.
- ax_size_i  in  3  log2 bytes per beat.
- ax_burst_i  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- beat_valid_o  out  1  beat record valid.
- beat_ready_i  in  1  beat consumed when valid && ready.
- beat_addr_o  out  AddrWidth  beat address.
- beat_idx_o  out  8  beat index, 0..len.
- beat_lower_o  out  OffW  lowest active byte lane.
- beat_upper_o  out  OffW  highest active byte lane.
- beat_strb_o  out  StrbWidth  lanes lower..upper set; all zero when err.
- beat_last_o  out  1  idx == len.
- beat_err_o  out  1  descriptor illegal; constant across the burst.

## Operation
- States: IDLE, BURST.
- In IDLE, ax_ready_o = 1. In BURST, ax_ready_o = beat_valid_o && beat_ready_i && beat_last_o, so back-to-back bursts run with no bubble.
- On accept, latch the descriptor, then compute:
  - nbytes = 1 << size
  - aligned = (addr >> size) << size
  - total = nbytes*(len+1)
  - wrap_base = addr & ~(total-1)
- Beat 0 address is addr for every burst type.
- Beat i>0 address by burst type:
  - FIXED: addr.
  - INCR: aligned + i*nbytes.
  - WRAP: aligned + i*nbytes; if the result is ≥ wrap_base+total, subtract total.
  - Reserved (11): computed as INCR.
- Next address is an incremental register update (add nbytes, compare against the wrap limit). No multiplier.
- Lanes:
  - lower = beat_addr mod StrbWidth.
  - upper = (beat_addr aligned to size) mod StrbWidth + nbytes − 1.
  - FIXED repeats beat 0's lanes on every beat.
- beat_err_o is 1 if any of these hold:
  - nbytes > StrbWidth;
  - burst == 11;
  - WRAP with len ∉ {1,3,7,15};
  - WRAP with addr ≠ aligned;
  - INCR with (aligned + total − 1) in a different 4 KiB page than addr.
- When beat_err_o = 1, the block still emits len+1 beats so downstream can return responses. beat_strb_o = 0, and lanes and address are computed as above with nbytes clamped to StrbWidth.
- Address arithmetic is modulo 2^AddrWidth. No carry out.

## Timing
- Reset values: state IDLE, beat_valid_o 0, ax_ready_o 1, and all beat_* outputs 0.
- Latency: beat 0 is valid the cycle after descriptor acceptance. After that, one beat per cycle while beat_ready_i = 1.
- All beat_* outputs are registered and must hold stable while beat_valid_o && !beat_ready_i.
- On last-beat handshake with no new descriptor: go to IDLE and clear beat_valid_o next cycle.
- On last-beat handshake with a new descriptor accepted in the same cycle: the new burst's beat 0 appears next cycle.
- len = 0: a single beat, with beat_last_o = 1 on beat 0.
- Reset asserted mid-burst: outputs return to reset values immediately. No residual beats after release.

## Test plan
- INCR, DataWidth 64, addr 0x1003, size 2, len 3 -> expect:
  - addrs 0x1003, 0x1004, 0x1008, 0x100C;
  - lower 3, 4, 0, 4; upper 3, 7, 3, 7;
  - strb 0x08, 0xF0, 0x0F, 0xF0;
  - last only on idx 3; err 0.
- WRAP, addr 0x38, size 3, len 3 -> addrs 0x38, 0x20, 0x28, 0x30; strb 0xFF each; err 0.
- FIXED, addr 0x104, size 1, len 2 -> three beats at 0x104, lower 4, upper 5, strb 0x30.
- Errors, each must produce the stated beat count with err 1 and strb 0:
  - WRAP len 2 -> 3 beats;
  - INCR addr 0xFF8, size 3, len 1 -> 2 beats (crosses 4 KiB);
  - size 4 on 64-bit bus, len 0 -> 1 beat;
  - burst 11, len 0 -> 1 beat.
- Backpressure and back-to-back:
  - INCR len 3 with beat_ready_i low for 3 cycles at idx 1 -> outputs unchanged throughout the stall.
  - Second descriptor presented during the last beat -> accepted in that cycle; its idx 0 appears the next cycle with no gap.
- Reset: assert rst_i at idx 2 of an INCR len 7 burst -> beat_valid_o 0 in the same cycle; after release ax_ready_o 1 and no beats until a new descriptor.
